iic_cfg_seq: RTL
================

// Module: iic_cfg_seq
// PURPOSE
//  Table-driven I2C configuration sequencer: a parametrised successor to the fixed
//  per-chip (MS7200/MS7210) init controllers. Walks an external synchronous table of
//  write / write-verify / delay / end entries for any number of devices, drives one
//  iic_dri master, retries failed read-back verifies, and reports done or error.
// PARAMETERS
//  TBL_AW     8       table address width; max 2**TBL_AW entries
//  DLY_UNIT   10000   clk cycles per DELAY count (1 ms @ 10 MHz)
//  PWR_DLY    100     DLY_UNITs waited after reset before the first fetch
//  MAX_RETRY  3       extra attempts per WRITE_VERIFY entry after the first fails
//  TIMEOUT    65535   max clk cycles waiting for busy to rise or fall
// PORTS
//  clk        in   1       system clock
//  rst        in   1       asynchronous reset, active high
//  start      in   1       1-cycle pulse; starts or restarts the sequence from entry 0
//  tbl_addr   out  TBL_AW  table read address
//  tbl_data   in   34      {op[33:32], dev_id[31:24], reg[23:8], data[7:0]}, valid 1 clk after tbl_addr
//  device_id  out  8       to iic_dri
//  iic_trig   out  1       1-cycle transfer trigger to iic_dri
//  w_r        out  1       1 = write, 0 = read
//  addr       out  16      register address
//  data_in    out  8       write data
//  busy       in   1       iic_dri busy
//  data_out   in   8       iic_dri read data
//  byte_over  in   1       iic_dri byte-complete strobe
//  init_over  out  1       sequence finished without error; held until the next start or rst
//  err        out  1       sequence aborted; held until the next start or rst
//  err_idx    out  TBL_AW  index of the failing entry; valid while err = 1
//  run        out  1       sequence in progress
// BEHAVIOUR
//  Reset: every output is 0; the FSM enters PWR (power-up delay).
//  - When PWR expires: go to IDLE and start automatically, exactly as if start were pulsed.
//  Opcodes:
//  - 0 WRITE
//  - 1 WRITE_VERIFY
//  - 2 DELAY (data*DLY_UNIT cycles; data = 0 means no wait)
//  - 3 END
//  FSM states:
//  - PWR: wait PWR_DLY*DLY_UNIT cycles -> IDLE.
//  - IDLE: on start -> FETCH. Clears idx, init_over, err; sets run.
//  - FETCH: drive tbl_addr = idx -> DECODE on the next cycle.
//  - DECODE: register the tbl_data fields and dispatch on op.
//  - WR_ISSUE: wait for busy = 0, then iic_trig = 1 for one cycle with w_r = 1 -> WR_ACK.
//  - WR_ACK: wait for busy = 1 -> WR_DONE.
//  - WR_DONE: wait for busy = 0. WRITE -> NEXT; WRITE_VERIFY -> RD_ISSUE.
//  - RD_ISSUE, RD_ACK, RD_DONE: same handshake with w_r = 0. data_out is captured on byte_over.
//  - CHECK: compare captured byte with data.
//    - Match -> NEXT.
//    - Mismatch with retry count < MAX_RETRY -> retry count +1, back to WR_ISSUE.
//    - Otherwise -> ERR.
//  - DLY: count data*DLY_UNIT cycles -> NEXT.
//  - NEXT: idx + 1, retry count = 0 -> FETCH. If idx = 2**TBL_AW-1 -> DONE (no wrap).
//  - END -> DONE: init_over = 1, run = 0 -> IDLE.
//  - ERR: err = 1, err_idx = idx, run = 0 -> IDLE.
//  Timeout: a watchdog reloads on each entry to *_ACK or *_DONE. If TIMEOUT cycles pass
//  without the awaited busy edge -> ERR.
//  Start handling: start while run = 1 is ignored. start in IDLE after DONE or ERR reruns
//  the sequence from entry 0.
//  Driver outputs: device_id, addr and data_in are held stable from the trig cycle until
//  busy falls.
//  Reset mid-transfer: all state clears at once. iic_trig drops to 0 without waiting for busy.
//  Widths: the delay counter holds 8-bit data * DLY_UNIT without overflow.
//  - Retry counter width: clog2(MAX_RETRY+1).
// TESTING
//  1. Table {W 0xB2/0x0003=0x55, END}; driver model busy 20 clk -> one trig, w_r=1,
//     addr=0x0003, then init_over=1, err=0.
//  2. WRITE_VERIFY data 0xA5; model returns 0xA5 -> 1 write + 1 read, init_over=1.
//     Model returns 0x00 always -> 4 writes + 4 reads, err=1, err_idx=0.
//  3. DELAY data=3, DLY_UNIT=10 -> 30 (+/-2 fetch cycles) between neighbouring trigs;
//     data=0 -> no idle gap.
//  4. busy never rises after trig, TIMEOUT=100 -> err=1 within 102 clk of trig.
//  5. Assert rst mid-WR_DONE -> all outputs 0 in the same cycle; after PWR expires the
//     sequence reruns from idx 0.
//  6. start pulsed while run=1 -> ignored; start after DONE -> second full pass,
//     init_over drops then returns to 1.

Source files
------------

// File: rtl/iic_cfg_seq.sv
// Table-driven I2C configuration sequencer. Walks an external synchronous command table
// and drives one iic_dri master. Entry types: write, verified write, delay and end.
module iic_cfg_seq #(
    parameter int unsigned TBL_AW    = 8,
    parameter int unsigned DLY_UNIT  = 10000,
    parameter int unsigned PWR_DLY   = 100,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [33:0]       tbl_data,
    output logic [7:0]        device_id,
    output logic              iic_trig,
    output logic              w_r,
    output logic [15:0]       addr,
    output logic [7:0]        data_in,
    input  logic              busy,
    input  logic [7:0]        data_out,
    input  logic              byte_over,
    output logic              init_over,
    output logic              err,
    output logic [TBL_AW-1:0] err_idx,
    output logic              run
);

    localparam logic [1:0] OpWrite    = 2'd0;
    localparam logic [1:0] OpWrVerify = 2'd1;
    localparam logic [1:0] OpDelay    = 2'd2;

    localparam int unsigned PWR_CYC = PWR_DLY * DLY_UNIT;
    localparam int unsigned PWR_W   = (PWR_CYC > 1) ? $clog2(PWR_CYC) : 1;
    localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'((PWR_CYC > 0) ? PWR_CYC - 1 : 0);

    // Wide enough for 255 * DLY_UNIT.
    localparam int unsigned DLY_W = $clog2(255 * DLY_UNIT + 1);

    localparam int unsigned TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

    typedef enum logic [3:0] {
        StPwr,
        StIdle,
        StFetch,
        StDecode,
        StWrIssue,
        StWrAck,
        StWrDone,
        StRdIssue,
        StRdAck,
        StRdDone,
        StCheck,
        StDly,
        StNext,
        StDone,
        StErr
    } state_e;

    state_e            state;
    logic [PWR_W-1:0]  pwr_cnt;
    logic              auto_start;
    logic [TBL_AW-1:0] idx;
    logic [1:0]        op_q;
    logic [RTY_W-1:0]  retry;
    logic [TO_W-1:0]   wd_cnt;
    logic [DLY_W-1:0]  dly_cnt;
    logic [7:0]        rd_byte;

    // The table index is the registered read address; it is already stable in FETCH.
    assign tbl_addr = idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StPwr;
            pwr_cnt    <= '0;
            auto_start <= 1'b0;
            idx        <= '0;
            op_q       <= '0;
            retry      <= '0;
            wd_cnt     <= '0;
            dly_cnt    <= '0;
            rd_byte    <= '0;
            device_id  <= '0;
            iic_trig   <= 1'b0;
            w_r        <= 1'b0;
            addr       <= '0;
            data_in    <= '0;
            init_over  <= 1'b0;
            err        <= 1'b0;
            err_idx    <= '0;
            run        <= 1'b0;
        end else begin
            iic_trig <= 1'b0;

            if (byte_over && (state == StRdAck || state == StRdDone)) begin
                rd_byte <= data_out;
            end

            case (state)
                StPwr: begin
                    if (pwr_cnt == PWR_LAST) begin
                        auto_start <= 1'b1;
                        state      <= StIdle;
                    end else begin
                        pwr_cnt <= pwr_cnt + PWR_W'(1);
                    end
                end

                StIdle: begin
                    if (start || auto_start) begin
                        auto_start <= 1'b0;
                        idx        <= '0;
                        retry      <= '0;
                        init_over  <= 1'b0;
                        err        <= 1'b0;
                        err_idx    <= '0;
                        run        <= 1'b1;
                        state      <= StFetch;
                    end
                end

                StFetch: state <= StDecode;

                StDecode: begin
                    op_q <= tbl_data[33:32];
                    case (tbl_data[33:32])
                        OpWrite, OpWrVerify: begin
                            device_id <= tbl_data[31:24];
                            addr      <= tbl_data[23:8];
                            data_in   <= tbl_data[7:0];
                            state     <= StWrIssue;
                        end
                        OpDelay: begin
                            dly_cnt <= DLY_W'(tbl_data[7:0]) * DLY_W'(DLY_UNIT);
                            state   <= (tbl_data[7:0] == 8'd0) ? StNext : StDly;
                        end
                        default: state <= StDone;
                    endcase
                end

                StWrIssue: begin
                    if (!busy) begin
                        iic_trig <= 1'b1;
                        w_r      <= 1'b1;
                        wd_cnt   <= TO_LOAD;
                        state    <= StWrAck;
                    end
                end

                StWrAck: begin
                    if (busy) begin
                        wd_cnt <= TO_LOAD;
                        state  <= StWrDone;
                    end else if (wd_cnt == '0) begin
                        state <= StErr;
                    end else begin
                        wd_cnt <= wd_cnt - TO_W'(1);
                    end
                end

                StWrDone: begin
                    if (!busy) begin
                        state <= (op_q == OpWrVerify) ? StRdIssue : StNext;
                    end else if (wd_cnt == '0) begin
                        state <= StErr;
                    end else begin
                        wd_cnt <= wd_cnt - TO_W'(1);
                    end
                end

                StRdIssue: begin
                    if (!busy) begin
                        iic_trig <= 1'b1;
                        w_r      <= 1'b0;
                        wd_cnt   <= TO_LOAD;
                        state    <= StRdAck;
                    end
                end

                StRdAck: begin
                    if (busy) begin
                        wd_cnt <= TO_LOAD;
                        state  <= StRdDone;
                    end else if (wd_cnt == '0) begin
                        state <= StErr;
                    end else begin
                        wd_cnt <= wd_cnt - TO_W'(1);
                    end
                end

                StRdDone: begin
                    if (!busy) begin
                        state <= StCheck;
                    end else if (wd_cnt == '0) begin
                        state <= StErr;
                    end else begin
                        wd_cnt <= wd_cnt - TO_W'(1);
                    end
                end

                StCheck: begin
                    if (rd_byte == data_in) begin
                        state <= StNext;
                    end else if (retry < RTY_MAX) begin
                        retry <= retry + RTY_W'(1);
                        state <= StWrIssue;
                    end else begin
                        state <= StErr;
                    end
                end

                StDly: begin
                    if (dly_cnt <= DLY_W'(1)) begin
                        state <= StNext;
                    end else begin
                        dly_cnt <= dly_cnt - DLY_W'(1);
                    end
                end

                // Last table slot finishes the sequence instead of wrapping to entry 0.
                StNext: begin
                    retry <= '0;
                    if (idx == '1) begin
                        state <= StDone;
                    end else begin
                        idx   <= idx + TBL_AW'(1);
                        state <= StFetch;
                    end
                end

                StDone: begin
                    init_over <= 1'b1;
                    run       <= 1'b0;
                    state     <= StIdle;
                end

                StErr: begin
                    err     <= 1'b1;
                    err_idx <= idx;
                    run     <= 1'b0;
                    state   <= StIdle;
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule
